gpu_vga_scanout: RTL
====================

GPU_VGA_SCANOUT -- requirements
Module: gpu_vga_scanout

Interface
REQ-001 Parameter FG_COLOR, default 8'hFF, RGB332 colour driven for a framebuffer bit of 1.
REQ-002 Parameter BG_COLOR, default 8'h00, RGB332 colour driven for a framebuffer bit of 0 and for the border.
REQ-003 clk  input  1  pixel clock, 25.175 MHz, one pixel per cycle; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 x1  output  9  framebuffer read column, 0..319.
REQ-006 y1  output  8  framebuffer read row, 0..199.
REQ-007 enable_read1  output  1  framebuffer read-port enable.
REQ-008 read_value1  input  1  framebuffer pixel, valid one clk after the address is presented.
REQ-009 vga_r  output  3  red; vga_g  output  3  green; vga_b  output  2  blue.
REQ-010 vga_hsync  output  1  horizontal sync, active low.
REQ-011 vga_vsync  output  1  vertical sync, active low.
REQ-012 vblank  output  1  high while displayed line is outside 0..479.
REQ-013 frame_start  output  1  one-clk pulse aligned with output of pixel (0,0).

Function
REQ-014 h counter SHALL count 0..799 and wrap to 0; v counter SHALL increment when h wraps, count 0..524, then wrap to 0.
REQ-015 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 Image region: h 0..639 and v 40..439 (320x200 doubled 2x each axis, vertically centred).
REQ-018 In image region x1 SHALL equal h>>1 and y1 SHALL equal (v-40)>>1, both combinational from the counters, with enable_read1=1.
REQ-019 Outside image region x1=0, y1=0, enable_read1=0.
REQ-020 Two-stage pipeline: counter state at cycle t SHALL appear on all video outputs (rgb, syncs, vblank, frame_start) at cycle t+2; all outputs registered.
REQ-021 Stage 1 SHALL delay image/visible/sync flags one clk to align with read_value1.
REQ-022 Output colour: image region -> FG_COLOR if read_value1 else BG_COLOR; visible but outside image (border) -> BG_COLOR; non-visible -> 0.
REQ-023 frame_start SHALL be 1 exactly at output of h=0,v=0, i.e. once per 420000 clks.
REQ-024 read_value1 SHALL be ignored whenever the delayed image flag is 0.

Reset
REQ-025 On rst assertion, immediately: h=0, v=0, all pipeline flags cleared, vga_hsync=1, vga_vsync=1, rgb=0, vblank=1, frame_start=0, enable_read1=0.
REQ-026 After rst deassertion the first counter state (0,0) SHALL reach outputs two clks later, with frame_start=1 at that clk.
REQ-027 rst asserted mid-frame SHALL abort the frame; no partial sync pulse beyond the reset edge.

Structure
REQ-028 Package gpu_vga_pkg SHALL hold all timing constants (H/V visible, porch, sync, total) and image offset/size constants.
REQ-029 Sub-module gpu_vga_timing SHALL contain the h/v counters and raw visible/sync flags; gpu_vga_scanout holds address generation and pipeline.

Verification
REQ-030 Reset release, run 2 frames -> hsync low 96 clks every 800; vsync low 1600 clks every 420000; frame_start period 420000.
REQ-031 RAM model with 1-clk latency, checkerboard pattern -> output pixel (2x,2y+40) equals FG/BG of fb(x,y) for all x<320, y<200, each pixel repeated 2x2.
REQ-032 Monitor enable_read1 -> high for exactly 640x400 clks per frame, x1<=319, y1<=199 always.
REQ-033 Border rows v=0..39 and 440..479 with fb all ones -> rgb = BG_COLOR; blanking intervals rgb=0.
REQ-034 Assert rst at h=700,v=300 for 3 clks -> outputs take reset values asynchronously; frame_start 2 clks after release.
REQ-035 Transition v=524,h=799 -> next counter state (0,0), vblank falls and frame_start pulses on same output clk.

Source files
------------

// File: rtl/gpu_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_vga_pkg
// Brief    : 640x480@60 VGA timing constants and 320x200 image placement
//            shared by the scanout pipeline and its timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_vga_pkg;

    localparam int C_CNT_W = 10;

    // Horizontal timing, in pixel clocks
    localparam logic [C_CNT_W-1:0] C_H_VISIBLE     = 10'd640;
    localparam logic [C_CNT_W-1:0] C_H_FRONT_PORCH = 10'd16;
    localparam logic [C_CNT_W-1:0] C_H_SYNC_WIDTH  = 10'd96;
    localparam logic [C_CNT_W-1:0] C_H_BACK_PORCH  = 10'd48;
    localparam logic [C_CNT_W-1:0] C_H_TOTAL       = C_H_VISIBLE + C_H_FRONT_PORCH
                                                   + C_H_SYNC_WIDTH + C_H_BACK_PORCH;
    localparam logic [C_CNT_W-1:0] C_H_LAST        = C_H_TOTAL - 10'd1;
    localparam logic [C_CNT_W-1:0] C_H_SYNC_START  = C_H_VISIBLE + C_H_FRONT_PORCH;
    localparam logic [C_CNT_W-1:0] C_H_SYNC_END    = C_H_SYNC_START + C_H_SYNC_WIDTH;

    // Vertical timing, in lines
    localparam logic [C_CNT_W-1:0] C_V_VISIBLE     = 10'd480;
    localparam logic [C_CNT_W-1:0] C_V_FRONT_PORCH = 10'd10;
    localparam logic [C_CNT_W-1:0] C_V_SYNC_WIDTH  = 10'd2;
    localparam logic [C_CNT_W-1:0] C_V_BACK_PORCH  = 10'd33;
    localparam logic [C_CNT_W-1:0] C_V_TOTAL       = C_V_VISIBLE + C_V_FRONT_PORCH
                                                   + C_V_SYNC_WIDTH + C_V_BACK_PORCH;
    localparam logic [C_CNT_W-1:0] C_V_LAST        = C_V_TOTAL - 10'd1;
    localparam logic [C_CNT_W-1:0] C_V_SYNC_START  = C_V_VISIBLE + C_V_FRONT_PORCH;
    localparam logic [C_CNT_W-1:0] C_V_SYNC_END    = C_V_SYNC_START + C_V_SYNC_WIDTH;

    // 320x200 framebuffer shown pixel-doubled, centred vertically in 480 lines
    localparam logic [C_CNT_W-1:0] C_IMG_WIDTH     = 10'd320;
    localparam logic [C_CNT_W-1:0] C_IMG_HEIGHT    = 10'd200;
    localparam logic [C_CNT_W-1:0] C_IMG_V_OFFSET  = 10'd40;
    localparam logic [C_CNT_W-1:0] C_IMG_H_END     = C_IMG_WIDTH * 10'd2;
    localparam logic [C_CNT_W-1:0] C_IMG_V_END     = C_IMG_V_OFFSET + C_IMG_HEIGHT * 10'd2;

    // Per-pixel attributes carried alongside the framebuffer read.
    // Sync flags are stored as "sync active" so a cleared pipeline means idle.
    typedef struct packed {
        logic image;
        logic visible;
        logic line_visible;
        logic hsync_active;
        logic vsync_active;
        logic frame_origin;
    } scan_flags_t;

endpackage
`default_nettype wire

// File: rtl/gpu_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : gpu_vga_timing
// Brief    : Horizontal/vertical raster counters and raw (undelayed) visible
//            and sync flags decoded from them.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_vga_timing
    import gpu_vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [C_CNT_W-1:0] h_cnt,
    output logic [C_CNT_W-1:0] v_cnt,
    output logic               visible,
    output logic               line_visible,
    output logic               hsync_active,
    output logic               vsync_active,
    output logic               frame_origin
);

    logic [C_CNT_W-1:0] r_h_cnt;
    logic [C_CNT_W-1:0] r_v_cnt;

    // Raster scan: h wraps every line, v advances on each h wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == C_V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Decode the raw region flags for the current counter position
    always_comb begin
        line_visible = (r_v_cnt < C_V_VISIBLE);
        visible      = (r_h_cnt < C_H_VISIBLE) && line_visible;
        hsync_active = (r_h_cnt >= C_H_SYNC_START) && (r_h_cnt < C_H_SYNC_END);
        vsync_active = (r_v_cnt >= C_V_SYNC_START) && (r_v_cnt < C_V_SYNC_END);
        frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    assign h_cnt = r_h_cnt;
    assign v_cnt = r_v_cnt;

endmodule
`default_nettype wire

// File: rtl/gpu_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : gpu_vga_scanout
// Brief    : Scans a 1bpp 320x200 framebuffer out as 640x480 VGA, pixel
//            doubled and vertically centred, through a two-stage pipeline
//            (address -> RAM data / delayed flags -> registered video).
// Revision : 1.0 - initial release
// ============================================================================
module gpu_vga_scanout
    import gpu_vga_pkg::*;
#(
    parameter logic [7:0] FG_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] x1,
    output logic [7:0] y1,
    output logic       enable_read1,
    input  logic       read_value1,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vblank,
    output logic       frame_start
);

    logic [C_CNT_W-1:0] w_h_cnt;
    logic [C_CNT_W-1:0] w_v_cnt;
    logic               w_visible;
    logic               w_line_visible;
    logic               w_hsync_active;
    logic               w_vsync_active;
    logic               w_frame_origin;
    logic               w_image;
    logic [C_CNT_W-1:0] w_v_rel;
    logic               w_unused_bits;
    scan_flags_t        r_s1;
    logic [7:0]         w_pixel;
    logic [7:0]         r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_vblank;
    logic               r_frame_start;

    gpu_vga_timing u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_cnt        (w_h_cnt),
        .v_cnt        (w_v_cnt),
        .visible      (w_visible),
        .line_visible (w_line_visible),
        .hsync_active (w_hsync_active),
        .vsync_active (w_vsync_active),
        .frame_origin (w_frame_origin)
    );

    assign w_image = (w_h_cnt < C_IMG_H_END)
                  && (w_v_cnt >= C_IMG_V_OFFSET)
                  && (w_v_cnt < C_IMG_V_END);
    assign w_v_rel = w_v_cnt - C_IMG_V_OFFSET;

    // Framebuffer address: halve both axes inside the image, park at 0 outside
    always_comb begin
        x1           = '0;
        y1           = '0;
        enable_read1 = 1'b0;
        if (w_image) begin
            x1           = w_h_cnt[9:1];
            y1           = w_v_rel[8:1];
            enable_read1 = 1'b1;
        end
    end

    // Halving drops the LSBs; the MSB of the row offset is always 0 in-image
    assign w_unused_bits = ^{w_h_cnt[0], w_v_rel[0], w_v_rel[9]};

    // Stage 1: hold the region flags for the cycle the RAM data is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else begin
            r_s1.image        <= w_image;
            r_s1.visible      <= w_visible;
            r_s1.line_visible <= w_line_visible;
            r_s1.hsync_active <= w_hsync_active;
            r_s1.vsync_active <= w_vsync_active;
            r_s1.frame_origin <= w_frame_origin;
        end
    end

    // Colour select; RAM data is only trusted inside the image region
    always_comb begin
        w_pixel = 8'h00;
        if (r_s1.image) begin
            w_pixel = read_value1 ? FG_COLOR : BG_COLOR;
        end else if (r_s1.visible) begin
            w_pixel = BG_COLOR;
        end
    end

    // Stage 2: register every video output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb         <= 8'h00;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_vblank      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_pixel;
            r_hsync       <= ~r_s1.hsync_active;
            r_vsync       <= ~r_s1.vsync_active;
            r_vblank      <= ~r_s1.line_visible;
            r_frame_start <= r_s1.frame_origin;
        end
    end

    assign vga_r       = r_rgb[7:5];
    assign vga_g       = r_rgb[4:2];
    assign vga_b       = r_rgb[1:0];
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
